// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: shared MemOP encodings, responder FSM states and lane constants.
package dmem_resp_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;

  // MemOP in RISC-V funct3 encoding
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Unsigned-load encodings have no store counterpart
  function automatic logic op_legal(input logic [2:0] op, input logic wen);
    logic ok;
    case (op)
      MEMOP_B, MEMOP_H, MEMOP_W: ok = 1'b1;
      MEMOP_BU, MEMOP_HU:        ok = !wen;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: store byte-enable / write-data alignment and load extract/extend.
module dmem_lane_fmt
  import dmem_resp_pkg::*;
(
  input  logic [2:0]      op_i,
  input  logic [1:0]      lane_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [BE_W-1:0] be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [4:0]      sh_c;
  logic [XLEN-1:0] rsh_c;

  assign sh_c = {lane_i, 3'b000};

  // Lane masking for stores, shift-down and extension for loads
  always_comb begin
    be_o    = '0;
    rdata_o = '0;
    wdata_o = wdata_i << sh_c;
    rsh_c   = rword_i >> sh_c;
    case (op_i)
      MEMOP_B: begin
        be_o    = BE_W'(1) << lane_i;
        rdata_o = {{24{rsh_c[7]}}, rsh_c[7:0]};
      end
      MEMOP_BU: begin
        be_o    = BE_W'(1) << lane_i;
        rdata_o = {24'd0, rsh_c[7:0]};
      end
      MEMOP_H: begin
        be_o    = BE_W'(3) << lane_i;
        rdata_o = {{16{rsh_c[15]}}, rsh_c[15:0]};
      end
      MEMOP_HU: begin
        be_o    = BE_W'(3) << lane_i;
        rdata_o = {16'd0, rsh_c[15:0]};
      end
      MEMOP_W: begin
        be_o    = '1;
        rdata_o = rsh_c;
      end
      default: begin
        be_o    = '0;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: fixed-latency data-memory responder with byte/half/word access.
// Optional: DMEM_RESP_MISALIGN_CHK_EN turns misaligned H/HU/W into errors;
// otherwise the low address bits are forced to the access alignment.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_wen_i,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = 4;
  localparam logic [XLEN-1:0] SPAN = XLEN'(4 * DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            wen_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_err_q;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic [XLEN-1:0] off_c;
  logic            in_range_c;
  logic            mis_c;
  logic [1:0]      lane_c;
  logic [AW-1:0]   idx_c;
  logic [XLEN-1:0] rword_c;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wsh_c;
  logic [XLEN-1:0] ld_c;
  logic            commit_c;
  logic [XLEN-1:0] rsp_rdata_d;
  logic            rsp_err_d;

  assign idx_c   = AW'(off_c >> 2);
  assign rword_c = mem_q[idx_c];

  // Address decode, alignment handling and response value for the held request
  always_comb begin
    off_c      = addr_q - BASE;
    in_range_c = (addr_q >= BASE) && (off_c < SPAN);
    lane_c     = addr_q[1:0];
    mis_c      = 1'b0;
`ifdef DMEM_RESP_MISALIGN_CHK_EN
    case (op_q)
      MEMOP_H, MEMOP_HU: mis_c = addr_q[0];
      MEMOP_W:           mis_c = (addr_q[1:0] != 2'b00);
      default:           mis_c = 1'b0;
    endcase
`else
    case (op_q)
      MEMOP_H, MEMOP_HU: lane_c = {addr_q[1], 1'b0};
      MEMOP_W:           lane_c = 2'b00;
      default:           lane_c = addr_q[1:0];
    endcase
`endif
    rsp_err_d   = !in_range_c || !op_legal(op_q, wen_q) || mis_c;
    rsp_rdata_d = (rsp_err_d || wen_q) ? '0 : ld_c;
    commit_c    = (state_q == ST_BUSY) && (cnt_q == '0) && wen_q &&
                  !rsp_err_d && !rst_i;
  end

  dmem_lane_fmt u_lane_fmt (
    .op_i    (op_q),
    .lane_i  (lane_c),
    .wdata_i (wdata_q),
    .rword_i (rword_c),
    .be_o    (be_c),
    .wdata_o (wsh_c),
    .rdata_o (ld_c)
  );

  // Byte-enable store into the word array on the last BUSY edge
  always_ff @(posedge clk_i) begin
    if (commit_c) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (be_c[i]) mem_q[idx_c][8*i +: 8] <= wsh_c[8*i +: 8];
      end
    end
  end

  // Request/latency/response sequencing with registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wen_q       <= 1'b0;
      op_q        <= MEMOP_W;
      addr_q      <= BASE;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            wen_q       <= req_wen_i;
            op_q        <= req_op_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed bench with a byte-level memory model and per-cycle checker.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wen_i   (req_wen),
    .req_op_i    (req_op),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nfail = 0;
  bit in_flight = 1'b0;
  bit mon_en = 1'b0;
  int acc_edge = 0;
  logic [31:0] exp_rdata = '0;
  bit exp_err = 1'b0;
  logic [7:0] mdl [logic [31:0]];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference behaviour: byte-addressed memory, range/op/alignment rules
  task automatic model(input bit wen, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output bit err);
    longint unsigned a;
    longint unsigned lim;
    int size;
    logic [31:0] v;
    a    = 64'(addr);
    lim  = 64'(BASE) + 64'(4 * DEPTH);
    size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    err  = 1'b0;
    rd   = '0;
    if (a < 64'(BASE) || a >= lim) err = 1'b1;
    if (op == 3'b011 || op == 3'b110 || op == 3'b111 || (wen && op[2])) err = 1'b1;
`ifdef DMEM_RESP_MISALIGN_CHK_EN
    if ((a % 64'(size)) != 0) err = 1'b1;
`else
    a = a - (a % 64'(size));
`endif
    if (err) return;
    if (wen) begin
      for (int i = 0; i < size; i++) mdl[32'(a) + 32'(i)] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[32'(a) + 32'(i)];
      if (!op[2] && size == 1 && v[7])  v[31:8]  = '1;
      if (!op[2] && size == 2 && v[15]) v[31:16] = '1;
      rd = v;
    end
  endtask

  // Per-cycle handshake, latency and response-value checker
  always @(negedge clk) begin
    if (mon_en) begin
      if (in_flight) begin
        check("req_ready_busy", 32'(req_ready), 32'd0);
        check("rsp_valid_timing", 32'(rsp_valid), 32'(cyc >= acc_edge + int'(LAT)));
        if (rsp_valid) begin
          check("rsp_rdata", rsp_rdata, exp_rdata);
          check("rsp_err", 32'(rsp_err), 32'(exp_err));
        end
      end else begin
        check("req_ready_idle", 32'(req_ready), 32'd1);
        check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end
    end
  end

  task automatic xact(input bit wen, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold,
                      output logic [31:0] rd, output bit er);
    logic [31:0] m_rd;
    bit m_er;
    bit got;
    model(wen, op, addr, wdata, m_rd, m_er);
    @(negedge clk);
    exp_rdata = m_rd;
    exp_err   = m_er;
    req_wen   = wen;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    acc_edge  = cyc;
    in_flight = 1'b1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    nchk++;
    if (!got) begin
      nfail++;
      $display("FAIL rsp_timeout: got no rsp_valid expected within %0d cycles", LAT + 1);
    end
    rd = rsp_rdata;
    er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      req_valid = ~req_valid;
      req_wen   = 1'b1;
      req_addr  = addr + 32'd4;
      @(negedge clk);
      check("hold_stable", rsp_rdata, rd);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    in_flight = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    bit er;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_op = MEMOP_W;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    xact(1'b1, MEMOP_W, 32'h8000_0010, 32'hDEAD_BEEF, 0, rd, er);
    check("sw_rdata", rd, 32'd0);
    check("sw_err", 32'(er), 32'd0);
    xact(1'b0, MEMOP_W, 32'h8000_0010, 32'h0, 0, rd, er);
    check("lw_deadbeef", rd, 32'hDEAD_BEEF);
    check("lw_err", 32'(er), 32'd0);

    xact(1'b1, MEMOP_B, 32'h8000_0013, 32'h0000_0080, 0, rd, er);
    xact(1'b0, MEMOP_B, 32'h8000_0013, 32'h0, 0, rd, er);
    check("lb_sext", rd, 32'hFFFF_FF80);
    xact(1'b0, MEMOP_BU, 32'h8000_0013, 32'h0, 0, rd, er);
    check("lbu_zext", rd, 32'h0000_0080);
    xact(1'b0, MEMOP_W, 32'h8000_0010, 32'h0, 0, rd, er);
    check("lw_after_sb", rd, 32'h80AD_BEEF);

    xact(1'b1, MEMOP_W, 32'h8000_0020, 32'hCAFE_F00D, 0, rd, er);
    xact(1'b1, MEMOP_H, 32'h8000_0022, 32'h0000_1234, 0, rd, er);
    xact(1'b0, MEMOP_H, 32'h8000_0022, 32'h0, 0, rd, er);
    check("lh_1234", rd, 32'h0000_1234);
    xact(1'b0, MEMOP_W, 32'h8000_0020, 32'h0, 0, rd, er);
    check("lw_after_sh", rd, 32'h1234_F00D);

    xact(1'b1, MEMOP_W, 32'h8000_0FFC, 32'h0BAD_C0DE, 0, rd, er);
    xact(1'b0, MEMOP_W, 32'h7FFF_FFFC, 32'h0, 0, rd, er);
    check("oor_low_err", 32'(er), 32'd1);
    check("oor_low_rdata", rd, 32'd0);
    xact(1'b1, MEMOP_W, BASE + 32'(4 * DEPTH), 32'h1111_2222, 0, rd, er);
    check("oor_high_err", 32'(er), 32'd1);
    xact(1'b0, MEMOP_W, 32'h8000_0FFC, 32'h0, 0, rd, er);
    check("last_word_kept", rd, 32'h0BAD_C0DE);

    xact(1'b0, 3'b011, 32'h8000_0010, 32'h0, 0, rd, er);
    check("illegal_op_err", 32'(er), 32'd1);
    xact(1'b1, MEMOP_HU, 32'h8000_0010, 32'h5555_5555, 0, rd, er);
    check("store_hu_err", 32'(er), 32'd1);
    xact(1'b0, MEMOP_W, 32'h8000_0010, 32'h0, 0, rd, er);
    check("illegal_no_write", rd, 32'h80AD_BEEF);

    xact(1'b0, MEMOP_H, 32'h8000_0011, 32'h0, 0, rd, er);
`ifdef DMEM_RESP_MISALIGN_CHK_EN
    check("lh_mis_err", 32'(er), 32'd1);
    check("lh_mis_rdata", rd, 32'd0);
`else
    check("lh_mis_err", 32'(er), 32'd0);
    check("lh_mis_rdata", rd, 32'hFFFF_BEEF);
`endif

    // Stretched response while req_valid toggles
    xact(1'b0, MEMOP_W, 32'h8000_0020, 32'h0, 5, rd, er);
    check("stretched_rdata", rd, 32'h1234_F00D);

    // Reset on the commit edge of a store aborts it
    xact(1'b1, MEMOP_W, 32'h8000_0040, 32'h55AA_55AA, 0, rd, er);
    mon_en = 1'b0;
    @(negedge clk);
    req_wen = 1'b1; req_op = MEMOP_W; req_addr = 32'h8000_0040;
    req_wdata = 32'h1234_5678; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("busy_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);

    // Reset and req_valid together: nothing accepted
    rst = 1'b1; req_valid = 1'b1; req_wdata = 32'h9999_9999;
    @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rst_vs_req_ready", 32'(req_ready), 32'd1);
    repeat (LAT + 2) @(negedge clk);
    check("rst_vs_req_no_rsp", 32'(rsp_valid), 32'd0);
    mon_en = 1'b1;
    xact(1'b0, MEMOP_W, 32'h8000_0040, 32'h0, 0, rd, er);
    check("aborted_store", rd, 32'h55AA_55AA);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder: the slave end of the load/store port driven by the core's MemWr/MemOP control. It accepts one request at a time over a valid/ready handshake and holds a word-organised storage array. It performs byte/half/word writes with lane masking and sign- or zero-extended reads. The response returns after a programmable fixed latency, giving the core a realistic multi-cycle memory to stall against.

## Interface
- DEPTH, 1024: number of 32-bit words in storage.
- BASE, 32'h80000000: byte address of word 0.
- LATENCY, 2: cycles from request accept to rsp_valid, range 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_wen  in  1  1 = store, 0 = load (MemWr).
- req_op  in  3  MemOP in RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core consumes response.
- rsp_rdata  out  32  load data, extended per req_op; 0 for stores and errors.
- rsp_err  out  1  request rejected (range/op/alignment).

## Operation
- FSM states: IDLE, BUSY, RESP.
  - IDLE: req_ready=1. On req_valid, the request is registered (wen, op, addr, wdata), cnt is loaded with LATENCY-1, and the FSM goes to BUSY.
  - BUSY: decrements cnt. When cnt==0, goes to RESP; on that same edge the store commits or load data is registered, and err is registered.
  - RESP: rsp_valid=1. Outputs stay stable until rsp_ready. On rsp_valid&&rsp_ready, the FSM goes to IDLE.
- Word index = (addr-BASE)>>2. Byte lane = addr[1:0].
- Out of range (addr<BASE or addr>=BASE+4*DEPTH):
  - rsp_err=1, rsp_rdata=0, no write.
- Illegal op (011, 110, 111) raises err, with the same effect as out of range. Store with op 100/101 is also illegal.
- Store: byte mask B=0001<<lane, H=0011<<lane, W=1111. The masked lanes of the word are written with wdata shifted by 8*lane. Other lanes are unchanged.
- Load: the selected byte/half is shifted down. B/H are sign-extended from bit 7/15; BU/HU are zero-extended. W returns the whole word.
- Storage contents are not reset and are undefined until written.
- req_valid outside IDLE is ignored; no request is queued.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0.
- Accept on edge E. rsp_valid rises in the cycle after edge E+LATENCY. With LATENCY=1, BUSY lasts one cycle.
- Minimum request spacing is LATENCY+2 cycles, with rsp_ready held high.
- rsp_ready low stretches RESP indefinitely. Held outputs must not change while stretched.
- Reset in BUSY aborts the request, and a pending store is not committed. Reset in RESP drops the response; the store has already committed.
- Reset and req_valid in the same cycle: reset wins, and nothing is accepted.

## Configuration
- DMEM_RESP_MISALIGN_CHK_EN defined:
  - H/HU with addr[0]!=0 raises rsp_err=1, with no write and rdata=0.
  - W with addr[1:0]!=0 raises the same error.
- Macro undefined:
  - The low bits are forced to zero: H clears bit 0, W clears bits [1:0].
  - The access proceeds normally, and misalignment never raises err.

## Structure
- Shared package:
  - MemOP encodings MEMOP_B/H/W/BU/HU.
  - The FSM state enum.
  - Byte-mask width constant 4.
- Sub-module dmem_lane_fmt (combinational) produces the store byte-enable and shifted write data, plus the load extract/extend from op and lane. It is reused later by the core's load path.
- Storage is an inferred register array inside dmem_resp, with a byte-enable write.

## Test plan
- Reset, then SW 0xDEADBEEF @0x80000010, then LW @0x80000010: rdata=0xDEADBEEF, err=0. rsp_valid appears exactly LATENCY+1 cycles after the accept cycle.
- SB 0x80 @0x80000013, then LB @0x80000013 gives 0xFFFFFF80; LBU gives 0x00000080; LW @0x80000010 gives 0x80ADBEEF.
- SH 0x1234 @0x80000022, then LH gives 0x00001234; LW @0x80000020 gives 0x1234xxxx with the lower half unchanged.
- LW @0x7FFFFFFC and SW @BASE+4*DEPTH: err=1, rdata=0, and a later read shows memory unchanged.
- LH @0x80000011:
  - Macro defined: err=1.
  - Macro undefined: data from 0x80000010, err=0.
- Hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid: rsp outputs stable, req_ready=0, no second accept. Then assert rst in BUSY during an SW: the store is not committed.
